// File: rtl/bit_serializer.sv
// bit_serializer: converts a WIDTH-bit parallel word into a serial bit stream,
// one bit per clock, with a valid/ready handshake on the parallel side.
// Bit order is selected by MSB_FIRST. The optional one-word holding register
// (zero-bubble back-to-back words) is enabled by defining
// BIT_SERIALIZER_PREFETCH_EN; without it a word is accepted only in IDLE.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_done
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_en_q, ready_en_d;
`ifdef BIT_SERIALIZER_PREFETCH_EN
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
`endif

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] shifted;

  assign accept   = data_valid & data_ready;
  assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);

  // Remove the bit just emitted so the next one sits at the output position.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shift_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign shifted = {1'b0, shift_q[WIDTH-1:1]};
    end
  endgenerate

  // State and datapath registers; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its _d value from the same pre-edge snapshot.
      state_q     <= IDLE;
      // NOTE: the shift register is reset too (not just the state), so a word
      // interrupted by reset can never leak a stale bit onto serial_out.
      shift_q     <= '0;
      cnt_q       <= '0;
      ready_en_q  <= 1'b0;
`ifdef BIT_SERIALIZER_PREFETCH_EN
      hold_q      <= '0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      ready_en_q  <= ready_en_d;
`ifdef BIT_SERIALIZER_PREFETCH_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

  // Next-state logic for the IDLE/SHIFT controller.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_bit) begin
`ifdef BIT_SERIALIZER_PREFETCH_EN
          state_d = (hold_full_q || accept) ? SHIFT : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register, bit counter and holding register updates.
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    ready_en_d = 1'b1;
`ifdef BIT_SERIALIZER_PREFETCH_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    unique case (state_q)
      IDLE: begin
        // The holding register is always empty in IDLE, so load directly.
        if (accept) begin
          shift_d = data_in;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          cnt_d   = '0;
          shift_d = '0;
`ifdef BIT_SERIALIZER_PREFETCH_EN
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            // Word arriving exactly on the last bit skips the holding stage.
            shift_d = data_in;
          end
`endif
        end else begin
          shift_d = shifted;
          cnt_d   = cnt_q + CNT_W'(1);
`ifdef BIT_SERIALIZER_PREFETCH_EN
          if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs depend only on registered state; data_ready stays low until the
  // first edge after reset release.
  always_comb begin
    serial_valid = (state_q == SHIFT);
    serial_out   = serial_valid & (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
    word_done    = last_bit;
`ifdef BIT_SERIALIZER_PREFETCH_EN
    data_ready   = ready_en_q & ~hold_full_q;
`else
    data_ready   = ready_en_q & (state_q == IDLE);
`endif
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed testbench for bit_serializer (WIDTH=8). Two instances share the
// inputs: one MSB-first, one LSB-first. Define BIT_SERIALIZER_PREFETCH_EN
// for the bench and the RTL together to check the holding-register build.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif
  localparam int NCAP = 40;

  logic       clk;
  logic       areset_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       ready_m, out_m, valid_m, done_m;
  logic       ready_l, out_l, valid_l, done_l;

  int tests_run    = 0;
  int tests_failed = 0;

  logic cap_mv [NCAP];
  logic cap_mo [NCAP];
  logic cap_md [NCAP];
  logic cap_lv [NCAP];
  logic cap_lo [NCAP];
  logic cap_ld [NCAP];
  int   acc0, acc1;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk          (clk),
    .areset_n     (areset_n),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (ready_m),
    .serial_out   (out_m),
    .serial_valid (valid_m),
    .word_done    (done_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk          (clk),
    .areset_n     (areset_n),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (ready_l),
    .serial_out   (out_l),
    .serial_valid (valid_l),
    .word_done    (done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer up to two words and record outputs on every falling edge.
  task automatic run(input int nw, input logic [7:0] w0, input logic [7:0] w1,
                     input int ncyc);
    int idx;
    idx  = 0;
    acc0 = -1;
    acc1 = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      cap_mv[c] = valid_m; cap_mo[c] = out_m; cap_md[c] = done_m;
      cap_lv[c] = valid_l; cap_lo[c] = out_l; cap_ld[c] = done_l;
      if (idx < nw) begin
        data_valid = 1'b1;
        data_in    = (idx == 0) ? w0 : w1;
        if (ready_m) begin
          if (idx == 0) acc0 = c;
          else          acc1 = c;
          idx++;
        end
      end else begin
        data_valid = 1'b0;
        data_in    = 8'h00;
      end
    end
    data_valid = 1'b0;
    data_in    = 8'h00;
  endtask

  task automatic test_reset();
    areset_n   = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    #3;
    tests_run++;
    if ({out_m, valid_m, done_m, ready_m} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got out/valid/done/ready=%b expected 0000",
               {out_m, valid_m, done_m, ready_m});
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (ready_m !== 1'b0 || ready_l !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_held: got %b/%b expected 0/0", ready_m, ready_l);
    end
    #1 areset_n = 1'b1;
    #1;
    tests_run++;
    if (ready_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_before_edge: got %b expected 0", ready_m);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (ready_m !== 1'b1 || valid_m !== 1'b0 || out_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_after_edge: got ready=%b valid=%b out=%b expected 1 0 0",
               ready_m, valid_m, out_m);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] w;
    int p;
    w = 8'hA5;
    run(1, w, 8'h00, 14);
    tests_run++;
    if (acc0 < 0) begin
      tests_failed++;
      $display("FAIL msb_accept: word 0xA5 not accepted within 14 cycles");
      return;
    end
    for (int k = 0; k < 9; k++) begin
      p = acc0 + 1 + k;
      tests_run++;
      if (k < 8) begin
        if (cap_mv[p] !== 1'b1 || cap_mo[p] !== w[7-k] || cap_md[p] !== (k == 7)) begin
          tests_failed++;
          $display("FAIL msb_bit%0d: got v/o/d=%b%b%b expected 1%b%b",
                   k, cap_mv[p], cap_mo[p], cap_md[p], w[7-k], (k == 7));
        end
      end else if ({cap_mv[p], cap_mo[p], cap_md[p]} !== 3'b000) begin
        tests_failed++;
        $display("FAIL msb_idle_after: got v/o/d=%b%b%b expected 000",
                 cap_mv[p], cap_mo[p], cap_md[p]);
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    int p;
    w = 8'hA5;
    run(1, w, 8'h00, 14);
    tests_run++;
    if (acc0 < 0) begin
      tests_failed++;
      $display("FAIL lsb_accept: word 0xA5 not accepted within 14 cycles");
      return;
    end
    for (int k = 0; k < 10; k++) begin
      p = acc0 + 1 + k;
      tests_run++;
      if (k < 8) begin
        if (cap_lv[p] !== 1'b1 || cap_lo[p] !== w[k] || cap_ld[p] !== (k == 7)) begin
          tests_failed++;
          $display("FAIL lsb_bit%0d: got v/o/d=%b%b%b expected 1%b%b",
                   k, cap_lv[p], cap_lo[p], cap_ld[p], w[k], (k == 7));
        end
      end else if ({cap_lv[p], cap_lo[p]} !== 2'b00) begin
        tests_failed++;
        $display("FAIL lsb_idle_after%0d: got v/o=%b%b expected 00",
                 k, cap_lv[p], cap_lo[p]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0, w1;
    logic       ev, eo, ed;
    int s1, p;
    w0 = 8'h0D;
    w1 = 8'h0B;
    s1 = PREFETCH ? 8 : 9;
    run(2, w0, w1, 26);
    tests_run++;
    if (acc0 < 0 || acc1 < 0) begin
      tests_failed++;
      $display("FAIL b2b_accept: acc0=%0d acc1=%0d expected both accepted", acc0, acc1);
      return;
    end
    for (int k = 0; k < 19; k++) begin
      p = acc0 + 1 + k;
      if (k < 8) begin
        ev = 1'b1; eo = w0[7-k]; ed = (k == 7);
      end else if (k >= s1 && k < s1 + 8) begin
        ev = 1'b1; eo = w1[7-(k-s1)]; ed = (k == s1 + 7);
      end else begin
        ev = 1'b0; eo = 1'b0; ed = 1'b0;
      end
      tests_run++;
      if (cap_mv[p] !== ev || cap_mo[p] !== eo || cap_md[p] !== ed) begin
        tests_failed++;
        $display("FAIL b2b_pos%0d: got v/o/d=%b%b%b expected %b%b%b",
                 k, cap_mv[p], cap_mo[p], cap_md[p], ev, eo, ed);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] w0, w1;
    int s1, p;
    w0 = 8'hFF;
    w1 = 8'h00;
    s1 = PREFETCH ? 8 : 9;
    run(2, w0, w1, 26);
    tests_run++;
    if (acc0 < 0 || acc1 != acc0 + (PREFETCH ? 1 : 9)) begin
      tests_failed++;
      $display("FAIL busy_accept_time: acc0=%0d acc1=%0d expected acc1=acc0+%0d",
               acc0, acc1, PREFETCH ? 1 : 9);
      return;
    end
    for (int k = 0; k < 8; k++) begin
      p = acc0 + 1 + k;
      tests_run++;
      if (cap_mv[p] !== 1'b1 || cap_mo[p] !== 1'b1) begin
        tests_failed++;
        $display("FAIL busy_ones%0d: got v/o=%b%b expected 11", k, cap_mv[p], cap_mo[p]);
      end
    end
    p = acc0 + 1 + 8;
    tests_run++;
    if (cap_mv[p] !== PREFETCH || cap_mo[p] !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_between: got v/o=%b%b expected %b0", cap_mv[p], cap_mo[p], PREFETCH);
    end
    for (int k = 0; k < 8; k++) begin
      p = acc0 + 1 + s1 + k;
      tests_run++;
      if (cap_mv[p] !== 1'b1 || cap_mo[p] !== 1'b0 || cap_md[p] !== (k == 7)) begin
        tests_failed++;
        $display("FAIL busy_zeros%0d: got v/o/d=%b%b%b expected 10%b",
                 k, cap_mv[p], cap_mo[p], cap_md[p], (k == 7));
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    int guard, p;
    guard = 0;
    @(negedge clk);
    while (!ready_m && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    tests_run++;
    if (!ready_m) begin
      tests_failed++;
      $display("FAIL midrst_ready: data_ready never rose within 20 cycles");
      return;
    end
    data_valid = 1'b1;
    data_in    = 8'hF0;
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = 8'h00;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    tests_run++;
    if (valid_m !== 1'b1 || out_m !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_pre: got v/o=%b%b expected 11 on fourth bit", valid_m, out_m);
    end
    areset_n = 1'b0;
    #1;
    tests_run++;
    if ({out_m, valid_m, done_m, ready_m, valid_l} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL midrst_async: got out/valid/done/ready/valid_l=%b expected 00000",
               {out_m, valid_m, done_m, ready_m, valid_l});
    end
    repeat (2) @(posedge clk);
    #2 areset_n = 1'b1;
    w = 8'h81;
    run(1, w, 8'h00, 16);
    tests_run++;
    if (acc0 < 0) begin
      tests_failed++;
      $display("FAIL midrst_accept: 0x81 not accepted after reset");
      return;
    end
    for (int k = 0; k < 9; k++) begin
      p = acc0 + 1 + k;
      tests_run++;
      if (k < 8) begin
        if (cap_mv[p] !== 1'b1 || cap_mo[p] !== w[7-k] || cap_md[p] !== (k == 7)) begin
          tests_failed++;
          $display("FAIL midrst_bit%0d: got v/o/d=%b%b%b expected 1%b%b",
                   k, cap_mv[p], cap_mo[p], cap_md[p], w[7-k], (k == 7));
        end
      end else if (cap_mv[p] !== 1'b0) begin
        tests_failed++;
        $display("FAIL midrst_idle: got valid=%b expected 0", cap_mv[p]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time bound in case a wait above never completes.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: ports clk and areset_n.
REQ-002 Parameter WIDTH, default 8, SHALL set the parallel word width; legal range 2..32.
REQ-003 Parameter MSB_FIRST, default 1, SHALL select the bit order: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 areset_n  input  1  asynchronous active-low reset.
REQ-006 data_in  input  WIDTH  parallel word to serialize.
REQ-007 data_valid  input  1  data_in is valid this cycle.
REQ-008 data_ready  output  1  block accepts a word this cycle.
REQ-009 serial_out  output  1  serial bit stream; drives the downstream sequence detector's 1-bit input.
REQ-010 serial_valid  output  1  serial_out carries a data bit this cycle.
REQ-011 word_done  output  1  single-cycle pulse coinciding with the last bit of each word.

Function
REQ-012 A word SHALL be accepted only on a rising edge where data_valid and data_ready are both 1; data_in is ignored otherwise.
REQ-013 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-014 IDLE SHALL go to SHIFT on acceptance; otherwise IDLE holds.
REQ-015 On acceptance, the shift register SHALL load data_in and the bit counter SHALL load 0.
REQ-016 Latency SHALL be one cycle: a word accepted at edge N drives its first bit on serial_out during the cycle after edge N.
REQ-017 In SHIFT, the block SHALL emit exactly one bit per cycle for WIDTH consecutive cycles, in the order selected by MSB_FIRST, with serial_valid=1.
REQ-018 word_done SHALL be 1 only in the cycle where the bit counter equals WIDTH-1.
REQ-019 After the last bit, the FSM SHALL go to IDLE unless a next word is available (REQ-027).
REQ-020 In IDLE, serial_out and serial_valid SHALL be 0, so the downstream sees a constant 0 level.
REQ-021 serial_out, serial_valid and word_done SHALL be driven only from registered state, with no combinational path from inputs.
REQ-022 data_valid asserted while data_ready=0 SHALL be ignored without corrupting the word in flight.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-024 While areset_n=0, all state SHALL clear immediately, independent of clk: state=IDLE, counter=0, shift register=0, holding register empty.
REQ-025 Reset values SHALL be: serial_out=0, serial_valid=0, word_done=0; data_ready=0 while areset_n=0 and 1 from the first edge after release.
REQ-026 If reset asserts mid-word, the partial word SHALL be discarded and never resumed.

Configuration
REQ-027 Macro BIT_SERIALIZER_PREFETCH_EN SHALL control a one-word holding register.
- Defined: data_ready = holding register empty, in either state. A word accepted in SHIFT goes to the holding register. On the last-bit cycle with the holding register full, the FSM loads the shift register from it, stays in SHIFT and clears it, so back-to-back words have zero bubble. A word accepted in IDLE with the holding register empty loads the shift register directly.
- Undefined: there is no holding register and data_ready = (state==IDLE). Consecutive words are therefore separated by at least one IDLE cycle with serial_out=0.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1, send 0xA5 -> serial_out 1,0,1,0,0,1,0,1 on the 8 cycles after acceptance, serial_valid=1 throughout, word_done on the 8th cycle only.
REQ-029 MSB_FIRST=0, send 0xA5 -> serial_out 1,0,1,0,0,1,0,1 (bit0 first), then serial_out=0 and serial_valid=0 in IDLE.
REQ-030 Send 0x0D then 0x0B, data_valid held high -> with macro: 16 contiguous valid bits, 00001101 00001011; without macro: the same bits with exactly one serial_valid=0 cycle between the words.
REQ-031 Send 0xFF, change data_in to 0x00 with data_valid=1 while data_ready=0 -> eight 1s emitted (without macro: 0x00 is accepted only after returning to IDLE).
REQ-032 Pull areset_n low between clock edges after 3 bits of 0xF0 -> outputs go to 0 at once with no clk edge; after release, 0x81 serializes cleanly as 1,0,0,0,0,0,0,1.
